// File: rtl/serial_word_rx_if.sv
// Parallel-side and serial-side signals of the serial word receiver.
// The slave modport is the receiver; master is the driver/consumer side.
interface serial_word_rx_if #(
  parameter int unsigned W = 4
);
  logic         frame_start;
  logic         rl;
  logic         bit_in;
  logic         bit_valid;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         overrun;
  logic         abort;

  modport slave (
    input  frame_start, rl, bit_in, bit_valid, data_ready,
    output data_out, data_valid, busy, overrun, abort
  );

  modport master (
    output frame_start, rl, bit_in, bit_valid, data_ready,
    input  data_out, data_valid, busy, overrun, abort
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: assembles W-bit frames (LSB- or MSB-first)
// into a one-word valid/ready output buffer.
module serial_word_rx #(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            reset,
  serial_word_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic           abort_q, abort_d;
  logic           complete;
  logic [W-1:0]   word;

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] s, input logic lsb_first,
                                            input logic b);
    if (lsb_first) return {b, s[W-1:1]};
    else           return {s[W-2:0], b};
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    abort_d   = 1'b0;
    complete  = 1'b0;
    word      = shift_in(shreg_q, dir_q, bus.bit_in);

    if (bus.frame_start) begin
      // Restart from an empty register; a same-cycle bit becomes bit 0 of the new frame.
      abort_d = (state_q == StShift) && (cnt_q != '0);
      dir_d   = bus.rl;
      state_d = StShift;
      if (bus.bit_valid) begin
        shreg_d = shift_in('0, bus.rl, bus.bit_in);
        cnt_d   = CW'(1);
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (state_q == StShift && bus.bit_valid) begin
      shreg_d = word;
      if (cnt_q == CW'(W - 1)) begin
        complete = 1'b1;
        state_d  = StIdle;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (complete) begin
      if (!valid_q || bus.data_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q == StShift);
  assign bus.overrun    = overrun_q;
  assign bus.abort      = abort_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized bench for serial_word_rx: a bit-list reference model feeds a word
// scoreboard that a separate monitor drains on every output handshake.
module tb_serial_word_rx;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_word_rx_if #(.W(W)) bus ();

  serial_word_rx #(.W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bits of the current frame kept as a list.
  bit           m_busy, m_dir, m_valid, m_ovr, m_abt;
  bit           m_bits[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] assemble(input bit lsb_first);
    int unsigned v = 0;
    for (int i = 0; i < int'(W); i++)
      if (m_bits[i]) v += lsb_first ? (1 << i) : (1 << (int'(W) - 1 - i));
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_valid = 0; m_ovr = 0; m_abt = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  // Checks the state left by the previous edge, then drives inputs for the next edge.
  task automatic step(input bit fs, input bit r, input bit b, input bit bv, input bit rdy);
    bit           done;
    logic [W-1:0] word;
    @(posedge clk);
    #1;
    chk("data_valid", bus.data_valid, m_valid);
    chk("busy", bus.busy, m_busy);
    chk("overrun", bus.overrun, m_ovr);
    chk("abort", bus.abort, m_abt);
    bus.frame_start = fs;
    bus.rl          = r;
    bus.bit_in      = b;
    bus.bit_valid   = bv;
    bus.data_ready  = rdy;
    m_ovr = 0; m_abt = 0; done = 0; word = '0;
    if (fs) begin
      m_abt = m_busy && (m_bits.size() > 0);
      m_bits.delete();
      m_dir  = r;
      m_busy = 1;
      if (bv) m_bits.push_back(b);
    end else if (m_busy && bv) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        word = assemble(m_dir);
        done = 1;
        m_busy = 0;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        exp_q.push_back(word);
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, rdy);
  endtask

  // Sends a word as W consecutive bits in the given order.
  task automatic send_word(input logic [W-1:0] w, input bit lsb_first, input bit rdy);
    for (int i = 0; i < int'(W); i++)
      step(i == 0, lsb_first, lsb_first ? w[i] : w[int'(W) - 1 - i], 1, rdy);
  endtask

  // Monitor: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (reset && bus.data_valid && bus.data_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: unexpected word %0h with nothing expected", bus.data_out);
      end else begin
        chk("scoreboard word", bus.data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.frame_start = 0; bus.rl = 0; bus.bit_in = 0; bus.bit_valid = 0; bus.data_ready = 0;
    model_reset();
    #1;
    chk("reset data_out", bus.data_out, 0);
    chk("reset data_valid", bus.data_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // LSB-first 1,0,1,1 back to back
    step(1, 1, 1, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    idle(1);
    chk("lsb word", bus.data_out, 4'b1101);
    idle(0);

    // MSB-first 1,0,1,1 with two-cycle gaps
    step(1, 0, 1, 1, 0); idle(0); idle(0);
    step(0, 1, 0, 1, 0); idle(0); idle(0);
    step(0, 1, 1, 1, 0); idle(0); idle(0);
    step(0, 1, 1, 1, 0);
    idle(0);
    chk("msb word", bus.data_out, 4'b1011);
    idle(1); idle(0);

    // Backpressure: second completion is dropped
    send_word(4'hA, 1, 0);
    send_word(4'h5, 1, 0);
    idle(0);
    chk("bp hold word", bus.data_out, 4'hA);
    idle(1);
    idle(0);
    chk("bp drained", bus.data_valid, 0);

    // Consume and complete on the same edge
    send_word(4'h3, 0, 0);
    step(1, 1, 0, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 1);
    idle(0);
    chk("simul word", bus.data_out, 4'hE);
    idle(1);

    // Abort after two bits, then a fresh MSB-first frame with a same-cycle bit
    step(1, 1, 1, 1, 0); step(0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 0, 1, 0);
    idle(0);
    chk("abort word", bus.data_out, 4'b0110);
    idle(1);

    // Asynchronous reset with a buffered word and three bits shifted
    send_word(4'h9, 1, 0);
    step(1, 1, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 0, 1, 0);
    idle(0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst data_out", bus.data_out, 0);
    chk("rst data_valid", bus.data_valid, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst overrun", bus.overrun, 0);
    chk("rst abort", bus.abort, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    send_word(4'hC, 0, 0);
    idle(0);
    chk("post-rst word", bus.data_out, 4'hC);
    idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 11) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom));

    repeat (4) idle(1);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver for the shift-register serial link. It is the receiving end of a parallel-load / serial-shift transmitter. It collects W serial bits per frame, LSB-first or MSB-first, into a word, then presents the word on a valid/ready output port. A one-word output buffer lets the next frame shift in while the previous word waits to be consumed.

## Interface
- W, 4, word width in bits; legal range W >= 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  begins a frame; sampled on the rising edge.
- rl  input  1  bit order; 1 = LSB-first (transmitter shifting right), 0 = MSB-first. Sampled only with frame_start.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in carries a frame bit this cycle.
- data_out  output  W  received word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid is also 1.
- busy  output  1  a frame is in progress (state SHIFT).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- abort  output  1  one-cycle pulse: a partial frame was discarded by a new frame_start.

## Operation
- Internal state:
  - state: IDLE or SHIFT.
  - shreg[W-1:0]: shift register.
  - cnt: bit counter, $clog2(W+1) bits.
  - dir: latched copy of rl.
- Shift rule on each accepted bit:
  - dir=1: shreg <= {bit_in, shreg[W-1:1]}.
  - dir=0: shreg <= {shreg[W-2:0], bit_in}.
  - Either way, the first bit received ends at bit 0 (LSB-first) or bit W-1 (MSB-first).
- IDLE:
  - bit_valid without frame_start is ignored.
  - frame_start=1: latch dir <= rl, go to SHIFT.
  - If bit_valid=1 in the same cycle, that bit is accepted as bit 0 of the frame and cnt <= 1; otherwise cnt <= 0.
- SHIFT, no frame_start:
  - Each cycle with bit_valid=1 accepts one bit and increments cnt.
  - When the accepted bit is the W-th, the frame completes: the assembled word is the completed word, state goes to IDLE, cnt returns to 0.
- SHIFT, frame_start=1:
  - abort pulses for one cycle if cnt > 0; a restart with cnt = 0 does not pulse.
  - Partial data is discarded; dir <= rl.
  - The frame restarts exactly as from IDLE, including a same-cycle bit.
- Output buffer on frame completion:
  - data_valid=0: data_out <= word, data_valid <= 1.
  - data_valid=1 and data_ready=1: the old word is consumed and the new word is loaded in the same edge; data_valid stays 1.
  - data_valid=1 and data_ready=0: the new word is dropped, data_out is unchanged, overrun pulses.
- data_valid clears on a data_ready & data_valid edge with no simultaneous completion.
- data_out is stable while data_valid=1 and the word is not consumed.
- busy = (state == SHIFT).
- No bits are lost between back-to-back frames: a frame_start in the cycle after a completion is accepted normally.

## Timing
- Reset (asynchronous assert, reset=0), all cleared immediately, independent of clk:
  - state=IDLE, cnt=0, shreg=0, dir=0.
  - data_out=0, data_valid=0, busy=0, overrun=0, abort=0.
- Reset asserted mid-frame discards the partial word and any buffered word.
- Reset deassertion takes effect from the first rising edge after reset returns to 1.
- Latency: the last bit is accepted at edge k; data_out and data_valid=1 are visible after edge k.
  - A frame with one bit per cycle, starting with frame_start+bit_valid at edge 0, has data_valid=1 after edge W-1.
- overrun and abort are registered, high for exactly the one cycle following the triggering edge.
- Throughput: one word per W cycles sustained, provided data_ready is high at least once per W cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- LSB-first, W=4, rl=1: frame_start with bits 1,0,1,1 on four consecutive cycles.
  - Required: data_out=4'b1101, data_valid=1 after the 4th edge, busy low afterwards.
- MSB-first, rl=0: same bit sequence, with bit_valid gaps of 2 idle cycles between bits.
  - Required: data_out=4'b1011; cnt is not advanced during the gaps.
- Backpressure: data_ready=0 while two frames complete (0xA, then 0x5).
  - Required: data_out stays 0xA, overrun pulses once at the 2nd completion.
  - Then data_ready=1 for one cycle: data_valid drops to 0.
- Simultaneous consume and complete: data_ready=1 on the same edge as a completion.
  - Required: data_out updates to the new word, data_valid stays 1, no overrun.
- Abort: after 2 bits, assert frame_start with rl=0 and bit_valid=1, then send 3 more bits.
  - Required: abort pulses once, and the word contains only the 4 bits of the new frame.
- Reset mid-operation: assert reset=0 asynchronously between clock edges, with data_valid=1 and 3 bits shifted.
  - Required: all outputs are 0 immediately; a following complete frame is received correctly.
